// File: rtl/srl16_fifo.sv
// srl16_fifo: first-word-fall-through FIFO built on a bank of SRL16E-style shift
// registers, one per data bit. All bits share one shift enable (CE) and one 4-bit
// read address (A3..A0).
//
// Ports:
//   CLK          clock, rising edge
//   CLR          asynchronous active-high reset (the SRL bank itself is not reset)
//   in_data      write data
//   in_valid     write request
//   in_ready     FIFO can accept a write this cycle (low while CLR is high)
//   out_data     oldest entry, forced to 0 while out_valid is low
//   out_valid    out_data holds a valid entry
//   out_ready    consumer takes out_data this cycle
//   count        occupancy, 0..DEPTH
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AFULL_LEVEL
module srl16_fifo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       count,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    // Physical taps of one SRL16E; only 0..DEPTH-1 are ever addressed.
    localparam int unsigned SrlTaps  = 16;
    localparam logic [4:0]  DepthCnt = 5'(DEPTH);
    localparam logic [4:0]  AfullCnt = 5'(AFULL_LEVEL);

    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StFull   = 2'd2;

    logic [4:0]       count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             push, pop;
    logic             srl_ce;
    logic [3:0]       srl_addr;
    logic [WIDTH-1:0] srl_q [SrlTaps];
    logic [WIDTH-1:0] srl_d [SrlTaps];
    logic [WIDTH-1:0] srl_dout;

    // Handshakes come from the state register so they fall with CLR at once.
    assign in_ready  = (state_q != StFull) && !CLR;
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy: push and pop together leave count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state, kept in lockstep with count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (push) state_d = StActive;
            end
            StActive: begin
                if (push && !pop && (count_q == DepthCnt - 5'd1)) begin
                    state_d = StFull;
                end else if (pop && !push && (count_q == 5'd1)) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) state_d = StActive;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            count_q <= 5'd0;
            state_q <= StEmpty;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // SRL bank drive: the newest entry sits at tap 0, so the oldest is at
    // tap count-1. On push+pop the shift moves the next-oldest entry into the
    // unchanged read address.
    assign srl_ce   = push;
    assign srl_addr = (count_q == 5'd0) ? 4'd0 : 4'(count_q - 5'd1);

    always_comb begin
        srl_d = srl_q;
        if (srl_ce) begin
            srl_d[0] = in_data;
            for (int i = 1; i < SrlTaps; i++) begin
                srl_d[i] = srl_q[i-1];
            end
        end
    end

    // Storage has no reset, like the primitive it models.
    always_ff @(posedge CLK) begin
        srl_q <= srl_d;
    end

    assign srl_dout = srl_q[srl_addr];

    // Unwritten SRL contents must never leak out.
    assign out_data    = out_valid ? srl_dout : '0;
    assign count       = count_q;
    assign full        = (count_q == DepthCnt);
    assign empty       = (count_q == 5'd0);
    assign almost_full = (count_q >= AfullCnt);

endmodule

// File: doc/srl16_fifo.md
Name: srl16_fifo

Overview:
- Synchronous FIFO of up to 16 entries per data bit, with valid/ready handshakes on both sides.
- Storage is a bank of SRL16E-style shift registers, one per data bit, with a shared shift enable and a shared 4-bit read address.
- Sits between the soft-primitive library and client logic: it produces the CE and A3..A0 drive for the SRL bank and consumes the bank's Q outputs.
- Small control logic sits around it: an occupancy counter, flags and handshake gating.

Parameters:
- WIDTH, 8, data bits per entry (1..64).
- DEPTH, 16, maximum entries (2..16); the SRL address never exceeds DEPTH-1.
- AFULL_LEVEL, 12, count at or above which almost_full asserts (1..DEPTH).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  write data.
- in_valid  input  1  write request.
- in_ready  output  1  FIFO can accept a write this cycle.
- out_data  output  WIDTH  oldest entry (first-word-fall-through).
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  5  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.

Behaviour:
- Reset (CLR high, asynchronous, takes effect immediately, no clock needed):
  - count=0, empty=1, full=0, almost_full=0, out_valid=0, out_data=0.
  - in_ready=0 while CLR is high; in_ready=1 on the first cycle after release.
- SRL storage is not reset. Its contents are don't-care and never visible, because out_data is forced to 0 whenever out_valid=0.
- Push = in_valid && in_ready.
  - in_ready = !full && !CLR. A push is refused when full, even if a pop happens in the same cycle.
- Pop = out_valid && out_ready.
  - out_valid = !empty.
- Storage behaviour:
  - On push, every bit's shift register shifts by one and in_data enters index 0 (CE = push).
  - Read address = count-1 when count>0, else 0.
  - out_data = data[count-1] combinationally from the registered count.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged; the read address is also unchanged because the shift compensates.
  - neither: unchanged.
- Flags are decoded from the registered count with no extra latency, and are valid in the same cycle as count.
- Control state machine, tracked as a 2-bit encoded state in lockstep with count:
  - EMPTY (count=0):
    - push -> ACTIVE (count=1), or FULL if DEPTH==1 is excluded by parameter range.
    - pop is impossible (out_valid=0).
  - ACTIVE (0<count<DEPTH):
    - push only at count==DEPTH-1 -> FULL.
    - pop only at count==1 -> EMPTY.
    - otherwise stays ACTIVE.
  - FULL (count=DEPTH):
    - in_ready=0; pop -> ACTIVE (count=DEPTH-1).
    - The state in which both push and pop occur is unreachable from FULL.
- Latency:
  - A write at edge N is visible on out_data/out_valid in the cycle after edge N.
  - Single-entry fall-through latency is 1 cycle.
- Illegal or boundary inputs:
  - in_valid when full: ignored, no state change, data dropped by the writer's protocol.
  - out_ready when empty: ignored, count stays 0, no underflow.
  - count never exceeds DEPTH and never wraps below 0.
- Reset mid-operation: all queued data is discarded, and the outputs above take their reset values within the same cycle as CLR rising.

Test Plan:
- Reset release, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=0:
  - count = 1, 2, 3.
  - out_data=0x11 from the cycle after the first push.
  - empty 1->0.
- From count=3, pop 3 times with in_valid=0:
  - out_data sequence 0x11, 0x22, 0x33.
  - then count=0, empty=1, out_valid=0, out_data=0.
- Fill to 16 with values 0x00..0x0F:
  - full=1, in_ready=0, almost_full asserted from count=12.
  - a push of 0xAA while full is ignored.
  - draining returns 0x00..0x0F in order, with no 0xAA.
- Hold count=5 and assert push (0x5A) plus pop every cycle for 20 cycles:
  - count stays 5.
  - output order preserved.
  - 0x5A values appear after the original 5 entries.
- Assert CLR asynchronously mid-cycle with count=7:
  - count=0, out_valid=0, in_ready=0 immediately, without waiting for CLK.
  - after release, a first push of 0x3C is read back as 0x3C, with no stale data.
- Pop attempt while empty (out_ready=1, in_valid=0, 4 cycles):
  - count stays 0.
  - then a single push of 0x01 gives out_valid=1, out_data=0x01 the next cycle.
